// File: rtl/wbarb_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
// Optional same-cycle secondary bypass is selected with WBARB_BYPASS_EN.
package wbarb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_SEC,
        GNT_FORCE
    } grant_e;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    function automatic logic [(1<<REG_W)-1:0] rd_onehot(input logic [REG_W-1:0] rd);
        rd_onehot     = '0;
        rd_onehot[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/wbarb_fifo.sv
// Circular FIFO for secondary results; every slot's rd and valid bit are
// exposed so the parent can build the pending-register mask.
module wbarb_fifo
    import wbarb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [REG_W-1:0]        push_rd,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [REG_W-1:0]        head_rd,
    output logic [DATA_W-1:0]       head_data,
    output logic [3:0]              count,
    output logic [DEPTH-1:0]        ent_vld,
    output logic [DEPTH*REG_W-1:0]  ent_rd
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_push  = push && (count_q < DEPTH_C);
        do_pop   = pop && (count_q != 4'd0);
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = '{rd: push_rd, data: push_data};
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = next_ptr(rd_ptr_q);
        end
        count_d = count_q + 4'(do_push) - 4'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        ent_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_rd[i*REG_W +: REG_W] = mem_q[i].rd;
        end
    end

    assign ent_vld   = vld_q;
    assign count     = count_q;
    assign head_rd   = mem_q[rd_ptr_q].rd;
    assign head_data = mem_q[rd_ptr_q].data;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between WB (priority) and a queued secondary
// producer with starvation forcing. Define WBARB_BYPASS_EN for same-cycle bypass.
module wb_port_arbiter
    import wbarb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              sec_valid,
    input  logic [4:0]        sec_rd,
    input  logic [31:0]       sec_data,
    output logic              sec_ready,
    output logic              wb_hold,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [31:0]       pend_mask,
    output logic [3:0]        fifo_count
);

    localparam logic [3:0] DEPTH_C  = 4'(DEPTH);
    localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

    logic [3:0]             starve_q, starve_d;
    logic [3:0]             count;
    logic [REG_W-1:0]       head_rd;
    logic [DATA_W-1:0]      head_data;
    logic [DEPTH-1:0]       ent_vld;
    logic [DEPTH*REG_W-1:0] ent_rd;
    logic                   fifo_empty, sec_acc, wb_req, bypass, push, pop;
    grant_e                 grant;

    assign fifo_empty = (count == 4'd0);
    assign sec_acc    = sec_valid && (count < DEPTH_C);
    assign wb_req     = wb_we && (wb_rd != REG_ZERO);

    always_comb begin
        grant  = GNT_NONE;
        bypass = 1'b0;
        if ((starve_q == STARVE_C) && !fifo_empty) begin
            grant = GNT_FORCE;
        end else if (wb_req) begin
            grant = GNT_WB;
        end else if (!fifo_empty) begin
            grant = GNT_SEC;
        end
`ifdef WBARB_BYPASS_EN
        else if (sec_acc && (sec_rd != REG_ZERO)) begin
            grant  = GNT_SEC;
            bypass = 1'b1;
        end
`endif
    end

    assign pop  = rst_n && !bypass && ((grant == GNT_FORCE) || (grant == GNT_SEC));
    assign push = rst_n && sec_acc && (sec_rd != REG_ZERO) && !bypass;

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_C) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    wbarb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_rd   (sec_rd),
        .push_data (sec_data),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (count),
        .ent_vld   (ent_vld),
        .ent_rd    (ent_rd)
    );

    // Everything is held at zero while reset is asserted, including sec_ready.
    always_comb begin
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        wb_hold    = 1'b0;
        sec_ready  = 1'b0;
        pend_mask  = '0;
        fifo_count = '0;
        if (rst_n) begin
            sec_ready  = (count < DEPTH_C);
            fifo_count = count;
            wb_hold    = (grant == GNT_FORCE) && wb_req;
            case (grant)
                GNT_WB: begin
                    rf_we    = 1'b1;
                    rf_waddr = wb_rd;
                    rf_wdata = wb_data;
                end
                GNT_SEC, GNT_FORCE: begin
                    rf_we    = 1'b1;
                    rf_waddr = bypass ? sec_rd : head_rd;
                    rf_wdata = bypass ? sec_data : head_data;
                end
                default: ;
            endcase
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[i]) begin
                    pend_mask = pend_mask | rd_onehot(ent_rd[i*REG_W +: REG_W]);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed checks of wb_port_arbiter against a queue-based model.
// Honours WBARB_BYPASS_EN in the same way as the design.
module tb_wb_port_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n, wb_we, sec_valid;
    logic [4:0]  wb_rd, sec_rd;
    logic [31:0] wb_data, sec_data;
    logic        sec_ready, wb_hold, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pend_mask;
    logic [3:0]  fifo_count;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .sec_valid  (sec_valid),
        .sec_rd     (sec_rd),
        .sec_data   (sec_data),
        .sec_ready  (sec_ready),
        .wb_hold    (wb_hold),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pend_mask  (pend_mask),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   starve;
    int   n_checks = 0;
    int   n_errors = 0;

    logic        e_we, e_hold, e_ready;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_pend;
    int          e_count;
    bit          m_pop, m_push, m_was_empty;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: a plain queue plus a count of consecutive denials of the head.
    function automatic void model_eval();
        int  n;
        bit  wbreq, byp;
        n       = q.size();
        wbreq   = wb_we && (wb_rd != 0);
        byp     = 1'b0;
        e_we    = 0; e_hold = 0; e_waddr = 0; e_wdata = 0; e_pend = 0;
        e_ready = rst_n && (n < DEPTH);
        e_count = rst_n ? n : 0;
        m_pop   = 0; m_push = 0; m_was_empty = (n == 0);
        if (!rst_n) return;
        if (starve == STARVE_MAX && n > 0) begin
            e_we = 1; e_waddr = q[0].rd; e_wdata = q[0].data; e_hold = wbreq; m_pop = 1;
        end else if (wbreq) begin
            e_we = 1; e_waddr = wb_rd; e_wdata = wb_data;
        end else if (n > 0) begin
            e_we = 1; e_waddr = q[0].rd; e_wdata = q[0].data; m_pop = 1;
        end
`ifdef WBARB_BYPASS_EN
        else if (sec_valid && e_ready && sec_rd != 0) begin
            e_we = 1; e_waddr = sec_rd; e_wdata = sec_data; byp = 1;
        end
`endif
        m_push = sec_valid && e_ready && (sec_rd != 0) && !byp;
        foreach (q[i]) e_pend[q[i].rd] = 1'b1;
    endfunction

    function automatic void model_update();
        ent_t e;
        if (!rst_n) begin
            q.delete();
            starve = 0;
            return;
        end
        if (m_was_empty || m_pop) starve = 0;
        else if (starve < STARVE_MAX) starve++;
        if (m_pop) q.delete(0);
        if (m_push) begin
            e.rd = sec_rd; e.data = sec_data;
            q.push_back(e);
        end
    endfunction

    task automatic apply(input logic rn, input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic sv, input logic [4:0] srd, input logic [31:0] sd);
        rst_n = rn; wb_we = we; wb_rd = wrd; wb_data = wd;
        sec_valid = sv; sec_rd = srd; sec_data = sd;
        @(negedge clk);
        model_eval();
        check_eq("rf_we", rf_we, e_we);
        check_eq("wb_hold", wb_hold, e_hold);
        check_eq("sec_ready", sec_ready, e_ready);
        check_eq("pend_mask", pend_mask, e_pend);
        check_eq("fifo_count", fifo_count, e_count);
        if (e_we || !rn) begin
            check_eq("rf_waddr", rf_waddr, e_waddr);
            check_eq("rf_wdata", rf_wdata, e_wdata);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_cycle();
        apply(1, 0, 0, 0, 0, 0, 0);
        advance();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle_cycle();
        @(negedge clk);
        check_eq("drain_count", fifo_count, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        q.delete();
        starve = 0;

        // Reset with a pending secondary request: everything must read zero.
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 5'd3, 32'h1111, 1, 5'd5, 32'h2222);
            check_eq("rst_sec_ready", sec_ready, 0);
            check_eq("rst_rf_we", rf_we, 0);
            advance();
        end

        // Lone secondary push.
        apply(1, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        check_eq("lone_ready", sec_ready, 1);
        advance();
        apply(1, 0, 0, 0, 0, 0, 0);
`ifndef WBARB_BYPASS_EN
        check_eq("lone_we", rf_we, 1);
        check_eq("lone_addr", rf_waddr, 5);
        check_eq("lone_data", rf_wdata, 32'hDEADBEEF);
        check_eq("lone_pend", pend_mask, 32'h20);
`endif
        advance();
        apply(1, 0, 0, 0, 0, 0, 0);
        check_eq("lone_pend_clr", pend_mask, 0);
        advance();

        // Starvation: WB wins STARVE_MAX cycles, then the queued r7 is forced.
        apply(1, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
        check_eq("starve_c0_addr", rf_waddr, 3);
        advance();
        for (int c = 1; c <= STARVE_MAX; c++) begin
            apply(1, 1, 5'd3, 32'h33, 0, 0, 0);
            check_eq("starve_wb_addr", rf_waddr, 3);
            check_eq("starve_wb_hold", wb_hold, 0);
            advance();
        end
        apply(1, 1, 5'd3, 32'h33, 0, 0, 0);
        check_eq("starve_force_addr", rf_waddr, 7);
        check_eq("starve_force_data", rf_wdata, 32'h77);
        check_eq("starve_force_hold", wb_hold, 1);
        advance();
        apply(1, 1, 5'd3, 32'h33, 0, 0, 0);
        check_eq("starve_after_addr", rf_waddr, 3);
        check_eq("starve_after_hold", wb_hold, 0);
        advance();

        // Full: continuous WB, three back-to-back pushes.
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 5'd4, 32'h44, 1, 5'(10 + k), 32'(32'hA0 + k));
            if (k < 2) check_eq("full_ready_early", sec_ready, 1);
            else begin
                check_eq("full_ready_third", sec_ready, 0);
                check_eq("full_count", fifo_count, 2);
                check_eq("full_pend", pend_mask, 32'h0000_0C00);
            end
            advance();
        end
        drain();

        // r0 handling for both requesters.
        apply(1, 0, 0, 0, 1, 5'd0, 32'h55);
        check_eq("r0_push_ready", sec_ready, 1);
        check_eq("r0_push_we", rf_we, 0);
        advance();
        apply(1, 1, 5'd0, 32'h66, 0, 0, 0);
        check_eq("r0_pend", pend_mask, 0);
        check_eq("r0_count", fifo_count, 0);
        check_eq("r0_wb_we", rf_we, 0);
        check_eq("r0_wb_hold", wb_hold, 0);
        advance();

`ifdef WBARB_BYPASS_EN
        apply(1, 0, 0, 0, 1, 5'd9, 32'h99);
        check_eq("byp_we", rf_we, 1);
        check_eq("byp_addr", rf_waddr, 9);
        advance();
        apply(1, 0, 0, 0, 0, 0, 0);
        check_eq("byp_count", fifo_count, 0);
        advance();
`endif

        // Random traffic; small rd range makes duplicates common.
        for (int c = 0; c < 3000; c++) begin
            apply(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 99) < 60),
                  5'($urandom_range(0, 7)),
                  $urandom(),
                  ($urandom_range(0, 99) < 50),
                  5'($urandom_range(0, 7)),
                  $urandom());
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
